// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM state type and signed-overflow helper for serial arithmetic units
package serial_arith_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} sub_state_t;
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction
endpackage

// File: rtl/digit_subtractor.sv
// digit_subtractor: combinational W-bit digit a_dig - b_dig - bin -> d with borrow out bout
module digit_subtractor #(
  parameter int W = 1
) (
  input  logic [W-1:0] a_dig,
  input  logic [W-1:0] b_dig,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);
  assign {bout, d} = {1'b0, a_dig} - {1'b0, b_dig} - (W+1)'(bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: valid/ready N-bit a - b - bin computed W bits per cycle with a registered borrow
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);
  localparam int D = N / W;
  localparam int CW = $clog2(D) + 1;
  if (N % W != 0) begin : g_bad_w
    $error("serial_subtractor: N must be a multiple of W");
  end
  sub_state_t state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic brw_q, brw_d, bout_q, bout_d, ovf_q, ovf_d;
  logic [W-1:0] dig_d;
  logic dig_bout;
  logic [N+W-1:0] cat;
  logic [N-1:0] acc_sh;
  logic last;
  digit_subtractor #(.W(W)) u_dig (
    .a_dig(a_q[W-1:0]),
    .b_dig(b_q[W-1:0]),
    .bin  (brw_q),
    .d    (dig_d),
    .bout (dig_bout)
  );
  assign cat = {dig_d, acc_q};
  assign acc_sh = cat[N+W-1:W];
  assign last = cnt_q == CW'(D - 1);
  assign in_ready = state_q == S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf = ovf_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    brw_d = brw_q;
    cnt_d = cnt_q;
    diff_d = diff_q;
    bout_d = bout_q;
    ovf_d = ovf_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        state_d = S_BUSY;
        a_d = a;
        b_d = b;
        brw_d = bin;
        cnt_d = '0;
      end
      S_BUSY: begin
        a_d = a_q >> W;
        b_d = b_q >> W;
        acc_d = acc_sh;
        brw_d = dig_bout;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = S_DONE;
          diff_d = acc_sh;
          bout_d = dig_bout;
          ovf_d = sub_ovf(a_q[W-1], b_q[W-1], dig_d[W-1]);
        end
      end
      S_DONE: state_d = out_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      brw_q <= 1'b0;
      cnt_q <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      brw_q <= brw_d;
      cnt_q <= cnt_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      ovf_q <= ovf_d;
    end
  end
endmodule
